// File: rtl/ropuf_pair_compare.sv
// Ring-oscillator PUF measurement: settle, count edges over a window, compare all pairs.
// Optional tie mask output enabled by defining ROPUF_TIE_MASK_EN.
module ropuf_pair_compare #(
  parameter int NUM_RO     = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int WINDOW     = 1024,
  localparam int NPAIR     = NUM_RO * (NUM_RO - 1) / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_RO-1:0] ro_out,
  output logic              ro_en,
  output logic              busy,
  output logic [NPAIR-1:0]  resp,
  output logic              resp_valid
`ifdef ROPUF_TIE_MASK_EN
  ,output logic [NPAIR-1:0] resp_tie
`endif
);

  localparam int MAX_SW = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
  localparam int MAXC   = (MAX_SW > NPAIR) ? MAX_SW : NPAIR;
  localparam int CYC_W  = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [NUM_RO-1:0]  r_s1;
  logic [NUM_RO-1:0]  r_s2;
  logic [NUM_RO-1:0]  r_sd;
  logic [NUM_RO-1:0]  w_rise;
  logic [CNT_W-1:0]   r_cnt [NUM_RO];
  logic [CNT_W-1:0]   w_a;
  logic [CNT_W-1:0]   w_b;
  logic [NPAIR-1:0]   r_shadow;
  logic [NPAIR-1:0]   w_shadow_nxt;
  logic [NPAIR-1:0]   r_resp;
  logic               w_cmp_last;

  assign w_rise = r_s2 & ~r_sd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_sd <= '0;
    end else begin
      r_s1 <= ro_out;
      r_s2 <= r_s1;
      r_sd <= r_s2;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_cmp_last = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_SETTLE;
      S_SETTLE:  if (r_cyc == CYC_W'(SETTLE_CYC - 1)) w_nxt = S_MEASURE;
      S_MEASURE: if (r_cyc == CYC_W'(WINDOW - 1)) w_nxt = S_COMPARE;
      S_COMPARE: begin
        if (r_cyc == CYC_W'(NPAIR - 1)) begin
          w_nxt      = S_DONE;
          w_cmp_last = 1'b1;
        end
      end
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state || r_state == S_IDLE) r_cyc <= '0;
      else                                       r_cyc <= r_cyc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RO; i++) r_cnt[i] <= '0;
    end else if (r_state == S_IDLE && start) begin
      for (int i = 0; i < NUM_RO; i++) r_cnt[i] <= '0;
    end else if (r_state == S_MEASURE) begin
      for (int i = 0; i < NUM_RO; i++)
        if (w_rise[i] && r_cnt[i] != {CNT_W{1'b1}})
          r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  // Lexicographic (i,j) enumeration selects the single pair compared this cycle
  always_comb begin
    int unsigned p;
    w_a = '0;
    w_b = '0;
    p   = 0;
    for (int i = 0; i < NUM_RO; i++) begin
      for (int j = i + 1; j < NUM_RO; j++) begin
        if (r_cyc == CYC_W'(p)) begin
          w_a = r_cnt[i];
          w_b = r_cnt[j];
        end
        p++;
      end
    end
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int q = 0; q < NPAIR; q++)
      if (r_cyc == CYC_W'(q)) w_shadow_nxt[q] = (w_a > w_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_resp   <= '0;
    end else if (r_state == S_COMPARE) begin
      r_shadow <= w_shadow_nxt;
      if (w_cmp_last) r_resp <= w_shadow_nxt;
    end
  end

`ifdef ROPUF_TIE_MASK_EN
  logic [NPAIR-1:0] r_tie_sh;
  logic [NPAIR-1:0] w_tie_nxt;
  logic [NPAIR-1:0] r_tie;

  always_comb begin
    w_tie_nxt = r_tie_sh;
    for (int q = 0; q < NPAIR; q++)
      if (r_cyc == CYC_W'(q)) w_tie_nxt[q] = (w_a == w_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tie_sh <= '0;
      r_tie    <= '0;
    end else if (r_state == S_COMPARE) begin
      r_tie_sh <= w_tie_nxt;
      if (w_cmp_last) r_tie <= w_tie_nxt;
    end
  end

  assign resp_tie = r_tie;
`endif

  assign ro_en      = (r_state == S_SETTLE) || (r_state == S_MEASURE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp       = r_resp;

endmodule

// File: tb/tb_ropuf_pair_compare.sv
// Directed bench for ropuf_pair_compare: vector table plus reset/busy/back-to-back sequences.
`timescale 1ns/1ps
module tb_ropuf_pair_compare;

  localparam int NR  = 4;
  localparam int SC  = 8;
  localparam int WN  = 240;
  localparam int NP  = 6;
  localparam int LAT = SC + WN + NP + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NR-1:0] ro_out = '0;
  logic          ro_en, busy, resp_valid;
  logic [NP-1:0] resp;
  logic          ro_en4, busy4, resp_valid4;
  logic [NP-1:0] resp4;
`ifdef ROPUF_TIE_MASK_EN
  logic [NP-1:0] resp_tie, resp_tie4;
`endif

  ropuf_pair_compare #(
    .NUM_RO(NR), .CNT_W(16), .SETTLE_CYC(SC), .WINDOW(WN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_out(ro_out),
    .ro_en(ro_en), .busy(busy), .resp(resp), .resp_valid(resp_valid)
`ifdef ROPUF_TIE_MASK_EN
    , .resp_tie(resp_tie)
`endif
  );

  ropuf_pair_compare #(
    .NUM_RO(NR), .CNT_W(4), .SETTLE_CYC(SC), .WINDOW(WN)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_out(ro_out),
    .ro_en(ro_en4), .busy(busy4), .resp(resp4), .resp_valid(resp_valid4)
`ifdef ROPUF_TIE_MASK_EN
    , .resp_tie(resp_tie4)
`endif
  );

  always #5 clk = ~clk;

  // Oscillators derived from absolute time so equal periods give identical waves;
  // the +3 ns offset keeps toggles away from clock edges.
  int per [NR];
  int t_ns = 0;
  always #1 begin
    t_ns++;
    for (int i = 0; i < NR; i++)
      ro_out[i] = (per[i] == 0) ? 1'b0 : 1'(((t_ns + 3) / (per[i] * 5)) % 2);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          p [NR];
    logic [NP-1:0] r;
    logic [NP-1:0] t;
    bit          c4;
    string       nm;
  } vec_t;

  vec_t tbl [5];

  task automatic set_per(input int a, input int b, input int c, input int d);
    per[0] = a; per[1] = b; per[2] = c; per[3] = d;
    repeat (10) @(negedge clk);
  endtask

  task automatic run(input string nm, input logic [NP-1:0] er,
                     input logic [NP-1:0] et, input bit c4,
                     input int poke, input bit hold0);
    int n;
    int nz;
    bit got;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    nz = 0;
    got = 1'b0;
    chk({nm, "_busy_rise"}, busy, 1);
    while (n < LAT + 50 && !got) begin
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (resp != '0) nz++;
        @(negedge clk);
        n++;
        start = (n == poke);
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, got ? n : -1, LAT);
    chk({nm, "_resp"}, resp, er);
`ifdef ROPUF_TIE_MASK_EN
    chk({nm, "_tie"}, resp_tie, et);
`else
    if (et != et) chk({nm, "_tie_unused"}, 0, 1);
`endif
    if (c4) begin
      chk({nm, "_sat_valid"}, resp_valid4, 1);
      chk({nm, "_sat_resp"}, resp4, 6'b000000);
`ifdef ROPUF_TIE_MASK_EN
      chk({nm, "_sat_tie"}, resp_tie4, 6'b111111);
`endif
    end
    if (hold0) chk({nm, "_resp_held0"}, nz, 0);
    @(negedge clk);
    chk({nm, "_busy_fall"}, busy, 0);
    chk({nm, "_valid_1cyc"}, resp_valid, 0);
  endtask

  initial begin
    int cnt;
    int n;
    int v1, v2;

    tbl[0] = '{p: '{4, 6, 8, 10}, r: 6'b111111, t: 6'b000000, c4: 0, nm: "mono"};
    tbl[1] = '{p: '{10, 8, 6, 4}, r: 6'b000000, t: 6'b000000, c4: 0, nm: "rev"};
    tbl[2] = '{p: '{4, 6, 6, 10}, r: 6'b110111, t: 6'b001000, c4: 0, nm: "eqpair"};
    tbl[3] = '{p: '{6, 4, 10, 8}, r: 6'b011110, t: 6'b000000, c4: 0, nm: "mixed"};
    tbl[4] = '{p: '{4, 4, 4, 4},  r: 6'b000000, t: 6'b111111, c4: 1, nm: "sat"};

    // Reset with oscillators toggling
    per[0] = 4; per[1] = 6; per[2] = 8; per[3] = 10;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", resp, 0);
    chk("rst_valid", resp_valid, 0);
`ifdef ROPUF_TIE_MASK_EN
    chk("rst_tie", resp_tie, 0);
`endif
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid || busy) cnt++;
    end
    chk("idle_no_valid", cnt, 0);

    for (int k = 0; k < 5; k++) begin
      set_per(tbl[k].p[0], tbl[k].p[1], tbl[k].p[2], tbl[k].p[3]);
      run(tbl[k].nm, tbl[k].r, tbl[k].t, tbl[k].c4, 0, 0);
    end

    // start pulses while busy must not queue a second evaluation
    set_per(4, 6, 8, 10);
    run("busyprot", 6'b111111, 6'b000000, 0, 100, 0);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (resp_valid || busy) cnt++;
    end
    chk("busyprot_no_second", cnt, 0);

    // start held high: back-to-back runs separated by one IDLE cycle
    @(negedge clk);
    start = 1'b1;
    n = 0;
    v1 = -1;
    v2 = -1;
    while (n < 2 * LAT + 50 && v2 < 0) begin
      @(negedge clk);
      n++;
      if (resp_valid) begin
        if (v1 < 0) v1 = n;
        else begin
          v2 = n;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first", v1, LAT);
    chk("b2b_second", v2, 2 * LAT + 1);
    chk("b2b_resp", resp, 6'b111111);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_stop", busy, 0);

    // Reset halfway through MEASURE, then restart
    set_per(6, 4, 10, 8);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (127) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp", resp, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ro_en", ro_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid || busy || resp != '0) cnt++;
    end
    chk("mid_quiet", cnt, 0);
    run("mid_rerun", 6'b011110, 6'b000000, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ropuf_pair_compare.md
# ropuf_pair_compare

Measurement and comparison stage placed directly downstream of the ring-oscillator bank (`ro1`…`ro4`). It does four things:
- drives the shared oscillator enable;
- counts rising edges of every oscillator output over a fixed window of `clk` cycles;
- compares every oscillator pair one pair per cycle to build the PUF response word;
- presents that word with a one-cycle valid strobe.

## Interface
Parameters:
- `NUM_RO`, 4: number of oscillators; must be ≥ 2.
- `CNT_W`, 16: edge-counter width.
- `SETTLE_CYC`, 8: cycles the oscillators run before counting starts (≥ 1).
- `WINDOW`, 1024: counting window in `clk` cycles (≥ 1).
- Derived `NPAIR` = `NUM_RO*(NUM_RO-1)/2`.

Ports:
- `clk` in 1: sole clock. Oscillator outputs must toggle slower than `clk`/2.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one evaluation. Sampled only in IDLE.
- `ro_out` in `NUM_RO`: raw oscillator outputs, asynchronous to `clk`.
- `ro_en` out 1: enable to all oscillators.
- `busy` out 1: high in every state except IDLE.
- `resp` out `NPAIR`: response word. Held until the next DONE.
- `resp_valid` out 1: one-cycle strobe, high in DONE.
- `resp_tie` out `NPAIR`: present only with `ROPUF_TIE_MASK_EN`; see Configuration.

## Operation
- **Input conditioning:** each `ro_out` bit passes through a 2-flop synchronizer, then an edge register. A rising edge is `sync & ~sync_d`.
- **State: IDLE.**
  - `ro_en`=0, `busy`=0.
  - `start`=1 moves to SETTLE, clears all counters and the cycle counter.
- **State: SETTLE.**
  - `ro_en`=1; counters held at 0.
  - Moves to MEASURE after `SETTLE_CYC` cycles.
- **State: MEASURE.**
  - `ro_en`=1. Each counter increments on a detected rising edge of its own oscillator.
  - Counters saturate at 2^`CNT_W`−1; no wrap.
  - Moves to COMPARE after `WINDOW` cycles. Edges are counted only while in MEASURE.
- **State: COMPARE.**
  - `ro_en`=0; counters frozen.
  - Pair index p runs 0…`NPAIR`−1, one pair per cycle.
  - Pairs (i,j) with i<j are enumerated lexicographically. For `NUM_RO`=4: p0=(0,1), p1=(0,2), p2=(0,3), p3=(1,2), p4=(1,3), p5=(2,3).
  - Shadow bit p = (cnt[i] > cnt[j]). Equal counts give 0.
- **State: DONE.**
  - Copies the shadow word to `resp`; `resp_valid`=1 for exactly one cycle.
  - Returns to IDLE.
- **`start` while busy:** ignored; not queued.
- **`start` held high:** starts back-to-back evaluations, with one IDLE cycle between them.
- **Reset:** `rst_n` low at any time, including mid-MEASURE, immediately forces:
  - IDLE;
  - `ro_en`, `busy`, `resp`, `resp_valid`, `resp_tie` = 0;
  - all counters = 0.
  - No partial response is ever published.

## Timing
- `start` sampled high at edge k:
  - SETTLE occupies cycles k+1 … k+`SETTLE_CYC`.
  - MEASURE occupies the next `WINDOW` cycles.
  - COMPARE occupies the next `NPAIR` cycles.
  - `resp_valid` is high in cycle k+1+`SETTLE_CYC`+`WINDOW`+`NPAIR`.
- `busy` rises in cycle k+1 and falls with the return to IDLE, one cycle after `resp_valid`.
- The synchronizer adds 3 cycles of edge-detect latency. Edges arriving within 3 cycles of the SETTLE→MEASURE or MEASURE→COMPARE boundary may fall either side; this gives a ±1 count tolerance.
- `resp` and `resp_tie` update only on the DONE cycle and are otherwise stable.

## Configuration
- **Macro:** `ROPUF_TIE_MASK_EN`.
- **Defined:**
  - Adds output `resp_tie`, built in COMPARE alongside `resp`.
  - Bit p = (cnt[i] == cnt[j]).
  - Published in DONE together with `resp`; reset value 0.
  - Downstream uses it to flag unreliable bits.
- **Undefined:**
  - `resp_tie` port and its logic are absent.
  - Ties resolve silently to 0.

## Test plan
Common settings: `NUM_RO`=4, `SETTLE_CYC`=8, `WINDOW`=240 unless noted.

- **Reset:** assert `rst_n`=0 with `ro_out` toggling → `ro_en`, `busy`, `resp`, `resp_valid`, `resp_tie` all 0. No `resp_valid` for 20 cycles after release without `start`.
- **Monotonic ordering:** RO0…RO3 with periods 4, 6, 8, 10 clk cycles; pulse `start` → counts ≈ 60, 40, 30, 24. `resp`=6'b111111, `resp_valid` exactly 8+240+6+1 = 255 cycles after the start edge, `busy` low the cycle after.
- **Reverse ordering:** periods 10, 8, 6, 4 → `resp`=6'b000000.
- **Equal pair:** periods RO1=RO2=6, RO0=4, RO3=10 → `resp`=6'b110111 (bit3=0). With `ROPUF_TIE_MASK_EN`, `resp_tie`=6'b001000.
- **Saturation and busy protection:**
  - `CNT_W`=4, all periods 4 → every counter saturates at 15. `resp`=0; with the macro, `resp_tie`=6'b111111.
  - `start` pulses during MEASURE produce no second evaluation.
- **Reset mid-operation:** drop `rst_n` for 2 cycles halfway through MEASURE, then restart. `resp` stays at its reset value 0 until the new run's DONE, and the new run's counts match an uninterrupted run ±1.
